axi2apb_bridge_mux: RTL and testbench

Parametrised AXI4-Lite slave to APB4 master bridge that fans out to `NUM_SLAVES` APB completers through an address-decoded `psel` vector. It buffers one AW, one W and one AR request, and round-robin arbitrates between a complete write and a read. It maps completer errors and unmapped addresses onto AXI response codes. It replaces the single-completer bridge at the AXI/APB boundary of the peripheral subsystem.

---
 rtl/axi2apb_pkg.sv | 28 ++
 rtl/apb_slave_decode.sv | 50 +++++
 rtl/axi2apb_bridge_mux.sv | 387 ++++++++++++++++++++++++++++++++++++++
 tb/tb_axi2apb_bridge_mux.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi2apb_pkg.sv
// -----------------------------------------------------------------------------
// axi2apb_pkg
// Shared types and constants for the AXI4-Lite to multi-completer APB4 bridge.
//   state_e      : bridge FSM states
//   RESP_*       : AXI response codes
//   idx_width()  : completer index width, clog2 with a floor of 1
// -----------------------------------------------------------------------------
package axi2apb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_ACCESS = 3'd2,
      ST_WRESP  = 3'd3,
      ST_RRESP  = 3'd4
   } state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // A single completer still needs a 1-bit index field so that the decode
   // can flag any address that falls outside region 0.
   function automatic int idx_width(input int n);
      return ($clog2(n) < 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/apb_slave_decode.sv
// -----------------------------------------------------------------------------
// apb_slave_decode
// Combinational address decoder for the APB completer fan-out.
//   addr : granted transaction address
//   sel  : one-hot completer select, all zero on a miss
//   idx  : completer index taken from addr[SLAVE_ADDR_W +: IDX_W]
//   miss : index beyond NUM_SLAVES or any address bit above the index field set
// -----------------------------------------------------------------------------
module apb_slave_decode
   import axi2apb_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int NUM_SLAVES   = 4,
   parameter int SLAVE_ADDR_W = 12,
   localparam int IDX_W       = idx_width(NUM_SLAVES)
) (
   input  logic [ADDR_W-1:0]     addr,
   output logic [NUM_SLAVES-1:0] sel,
   output logic [IDX_W-1:0]      idx,
   output logic                  miss
);

   localparam int HI_LSB = SLAVE_ADDR_W + IDX_W;

   logic [ADDR_W-1:0] upper_s;
   logic              idx_oob_s;

   // Extract the completer index and flag addresses outside the populated map.
   always_comb begin
      idx       = addr[SLAVE_ADDR_W +: IDX_W];
      upper_s   = addr >> HI_LSB;
      // Index field can encode more regions than are populated when
      // NUM_SLAVES is not a power of two.
      idx_oob_s = ({1'b0, idx} >= (IDX_W+1)'(NUM_SLAVES));
      miss      = idx_oob_s | (upper_s != {ADDR_W{1'b0}});
   end

   // Expand the index into a one-hot select, suppressed entirely on a miss.
   always_comb begin
      sel = {NUM_SLAVES{1'b0}};
      for (int k = 0; k < NUM_SLAVES; k++) begin
         if (!miss && (idx == IDX_W'(k))) begin
            sel[k] = 1'b1;
         end else begin
            sel[k] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/axi2apb_bridge_mux.sv
// -----------------------------------------------------------------------------
// axi2apb_bridge_mux
// AXI4-Lite slave to APB4 master bridge fanning out to NUM_SLAVES completers.
// One-entry AW, W and AR holding buffers; round-robin between a complete
// write and a read; one APB transfer in flight at a time.
//
// Ports
//   clk, rst                    : clock, asynchronous active-high reset
//   aw*/w*/b*/ar*/r*            : AXI4-Lite slave channels
//   paddr, psel, penable,
//   pwrite, pwdata, pstrb, pprot: APB4 requester outputs (psel one-hot)
//   prdata                      : completer k at [k*DATA_W +: DATA_W]
//   pready, pslverr             : one bit per completer
//
// Optional feature: define AXI2APB_TIMEOUT_EN to abort an ACCESS phase that
// sees no pready for TIMEOUT_CYCLES cycles (SLVERR, read data 0).
// -----------------------------------------------------------------------------
module axi2apb_bridge_mux
   import axi2apb_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int NUM_SLAVES     = 4,
   parameter int SLAVE_ADDR_W   = 12,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [ADDR_W-1:0]            awaddr,
   input  logic [2:0]                   awprot,
   input  logic                         awvalid,
   output logic                         awready,
   input  logic [DATA_W-1:0]            wdata,
   input  logic [DATA_W/8-1:0]          wstrb,
   input  logic                         wvalid,
   output logic                         wready,
   output logic [1:0]                   bresp,
   output logic                         bvalid,
   input  logic                         bready,
   input  logic [ADDR_W-1:0]            araddr,
   input  logic [2:0]                   arprot,
   input  logic                         arvalid,
   output logic                         arready,
   output logic [DATA_W-1:0]            rdata,
   output logic [1:0]                   rresp,
   output logic                         rvalid,
   input  logic                         rready,
   output logic [ADDR_W-1:0]            paddr,
   output logic [NUM_SLAVES-1:0]        psel,
   output logic                         penable,
   output logic                         pwrite,
   output logic [DATA_W-1:0]            pwdata,
   output logic [DATA_W/8-1:0]          pstrb,
   output logic [2:0]                   pprot,
   input  logic [NUM_SLAVES*DATA_W-1:0] prdata,
   input  logic [NUM_SLAVES-1:0]        pready,
   input  logic [NUM_SLAVES-1:0]        pslverr
);

   localparam int STRB_W = DATA_W / 8;
   localparam int IDX_W  = idx_width(NUM_SLAVES);

   // FSM and arbitration history
   state_e                state_q, state_d;
   logic                  last_write_q, last_write_d;

   // Request holding buffers
   logic                  aw_full_q, aw_full_d;
   logic [ADDR_W-1:0]     aw_addr_q, aw_addr_d;
   logic [2:0]            aw_prot_q, aw_prot_d;
   logic                  w_full_q, w_full_d;
   logic [DATA_W-1:0]     w_data_q, w_data_d;
   logic [STRB_W-1:0]     w_strb_q, w_strb_d;
   logic                  ar_full_q, ar_full_d;
   logic [ADDR_W-1:0]     ar_addr_q, ar_addr_d;
   logic [2:0]            ar_prot_q, ar_prot_d;

   // APB output registers and latched decode of the granted address
   logic [ADDR_W-1:0]     paddr_q, paddr_d;
   logic [NUM_SLAVES-1:0] psel_q, psel_d;
   logic                  penable_q, penable_d;
   logic                  pwrite_q, pwrite_d;
   logic [DATA_W-1:0]     pwdata_q, pwdata_d;
   logic [STRB_W-1:0]     pstrb_q, pstrb_d;
   logic [2:0]            pprot_q, pprot_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  miss_q, miss_d;

   // AXI response registers
   logic                  bvalid_q, bvalid_d;
   logic [1:0]            bresp_q, bresp_d;
   logic                  rvalid_q, rvalid_d;
   logic [1:0]            rresp_q, rresp_d;
   logic [DATA_W-1:0]     rdata_q, rdata_d;

   // Combinational helpers
   logic                  wr_pend_s, rd_pend_s;
   logic                  grant_wr_s, grant_rd_s;
   logic [ADDR_W-1:0]     gnt_addr_s;
   logic [NUM_SLAVES-1:0] dec_sel_s;
   logic [IDX_W-1:0]      dec_idx_s;
   logic                  dec_miss_s;
   logic                  sel_ready_s, sel_err_s;
   logic [DATA_W-1:0]     sel_rdata_s;
   logic                  timeout_s;
   logic [1:0]            acc_resp_s;

   // Round-robin: on contention grant the type not granted last; last_write
   // resets to 0 so the first contended grant goes to the write.
   assign wr_pend_s  = aw_full_q & w_full_q;
   assign rd_pend_s  = ar_full_q;
   assign grant_wr_s = wr_pend_s & (~rd_pend_s | ~last_write_q);
   assign grant_rd_s = rd_pend_s & (~wr_pend_s | last_write_q);
   assign gnt_addr_s = grant_wr_s ? aw_addr_q : ar_addr_q;

   apb_slave_decode #(
      .ADDR_W       (ADDR_W),
      .NUM_SLAVES   (NUM_SLAVES),
      .SLAVE_ADDR_W (SLAVE_ADDR_W)
   ) u_decode (
      .addr (gnt_addr_s),
      .sel  (dec_sel_s),
      .idx  (dec_idx_s),
      .miss (dec_miss_s)
   );

   // Masking with psel_q makes unselected completers' pready/pslverr invisible.
   assign sel_ready_s = |(pready & psel_q);
   assign sel_err_s   = |(pslverr & psel_q);

   // Select the read data slice of the granted completer.
   always_comb begin
      sel_rdata_s = {DATA_W{1'b0}};
      for (int k = 0; k < NUM_SLAVES; k++) begin
         if (idx_q == IDX_W'(k)) begin
            sel_rdata_s = prdata[k*DATA_W +: DATA_W];
         end else begin
            sel_rdata_s = sel_rdata_s;
         end
      end
   end

`ifdef AXI2APB_TIMEOUT_EN
   localparam int TMO_W = idx_width(TIMEOUT_CYCLES + 1);

   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

   // Count ACCESS cycles; the count restarts whenever the FSM leaves ACCESS.
   always_comb begin
      if (state_q == ST_ACCESS) begin
         tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      end else begin
         tmo_cnt_d = {TMO_W{1'b0}};
      end
      timeout_s = (state_q == ST_ACCESS) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
   end

   // Timeout counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt_q <= {TMO_W{1'b0}};
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
      end
   end
`else
   assign timeout_s = 1'b0;
`endif

   // A timeout completion (no pready) always reports SLVERR.
   assign acc_resp_s = (!sel_ready_s || sel_err_s) ? RESP_SLVERR : RESP_OKAY;

   // Buffer loads, arbitration and FSM next state with all register updates.
   always_comb begin
      state_d      = state_q;
      last_write_d = last_write_q;
      aw_full_d    = aw_full_q;
      aw_addr_d    = aw_addr_q;
      aw_prot_d    = aw_prot_q;
      w_full_d     = w_full_q;
      w_data_d     = w_data_q;
      w_strb_d     = w_strb_q;
      ar_full_d    = ar_full_q;
      ar_addr_d    = ar_addr_q;
      ar_prot_d    = ar_prot_q;
      paddr_d      = paddr_q;
      psel_d       = psel_q;
      penable_d    = penable_q;
      pwrite_d     = pwrite_q;
      pwdata_d     = pwdata_q;
      pstrb_d      = pstrb_q;
      pprot_d      = pprot_q;
      idx_d        = idx_q;
      miss_d       = miss_q;
      bvalid_d     = bvalid_q;
      bresp_d      = bresp_q;
      rvalid_d     = rvalid_q;
      rresp_d      = rresp_q;
      rdata_d      = rdata_q;

      // A buffer is only freed while full, so a load and a free never collide.
      if (awvalid && !aw_full_q) begin
         aw_full_d = 1'b1;
         aw_addr_d = awaddr;
         aw_prot_d = awprot;
      end else begin
         aw_full_d = aw_full_q;
      end
      if (wvalid && !w_full_q) begin
         w_full_d = 1'b1;
         w_data_d = wdata;
         w_strb_d = wstrb;
      end else begin
         w_full_d = w_full_q;
      end
      if (arvalid && !ar_full_q) begin
         ar_full_d = 1'b1;
         ar_addr_d = araddr;
         ar_prot_d = arprot;
      end else begin
         ar_full_d = ar_full_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (grant_wr_s || grant_rd_s) begin
               // Latch the granted request and its decode; psel is already
               // zero here if the address misses.
               state_d      = ST_SETUP;
               last_write_d = grant_wr_s;
               paddr_d      = gnt_addr_s;
               pwrite_d     = grant_wr_s;
               pprot_d      = grant_wr_s ? aw_prot_q : ar_prot_q;
               pwdata_d     = grant_wr_s ? w_data_q : {DATA_W{1'b0}};
               pstrb_d      = grant_wr_s ? w_strb_q : {STRB_W{1'b0}};
               psel_d       = dec_sel_s;
               idx_d        = dec_idx_s;
               miss_d       = dec_miss_s;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_SETUP: begin
            if (miss_q) begin
               // Unmapped address: answer DECERR without an APB access.
               psel_d = {NUM_SLAVES{1'b0}};
               if (pwrite_q) begin
                  aw_full_d = 1'b0;
                  w_full_d  = 1'b0;
                  bvalid_d  = 1'b1;
                  bresp_d   = RESP_DECERR;
                  state_d   = ST_WRESP;
               end else begin
                  ar_full_d = 1'b0;
                  rvalid_d  = 1'b1;
                  rresp_d   = RESP_DECERR;
                  rdata_d   = {DATA_W{1'b0}};
                  state_d   = ST_RRESP;
               end
            end else begin
               penable_d = 1'b1;
               state_d   = ST_ACCESS;
            end
         end

         ST_ACCESS: begin
            if (sel_ready_s || timeout_s) begin
               psel_d    = {NUM_SLAVES{1'b0}};
               penable_d = 1'b0;
               if (pwrite_q) begin
                  aw_full_d = 1'b0;
                  w_full_d  = 1'b0;
                  bvalid_d  = 1'b1;
                  bresp_d   = acc_resp_s;
                  state_d   = ST_WRESP;
               end else begin
                  // Read data is captured even alongside pslverr.
                  ar_full_d = 1'b0;
                  rvalid_d  = 1'b1;
                  rresp_d   = acc_resp_s;
                  rdata_d   = sel_ready_s ? sel_rdata_s : {DATA_W{1'b0}};
                  state_d   = ST_RRESP;
               end
            end else begin
               state_d = ST_ACCESS;
            end
         end

         ST_WRESP: begin
            if (bready) begin
               bvalid_d = 1'b0;
               state_d  = ST_IDLE;
            end else begin
               state_d = ST_WRESP;
            end
         end

         ST_RRESP: begin
            if (rready) begin
               rvalid_d = 1'b0;
               state_d  = ST_IDLE;
            end else begin
               state_d = ST_RRESP;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, buffer and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         last_write_q <= 1'b0;
         aw_full_q    <= 1'b0;
         aw_addr_q    <= {ADDR_W{1'b0}};
         aw_prot_q    <= 3'b000;
         w_full_q     <= 1'b0;
         w_data_q     <= {DATA_W{1'b0}};
         w_strb_q     <= {STRB_W{1'b0}};
         ar_full_q    <= 1'b0;
         ar_addr_q    <= {ADDR_W{1'b0}};
         ar_prot_q    <= 3'b000;
         paddr_q      <= {ADDR_W{1'b0}};
         psel_q       <= {NUM_SLAVES{1'b0}};
         penable_q    <= 1'b0;
         pwrite_q     <= 1'b0;
         pwdata_q     <= {DATA_W{1'b0}};
         pstrb_q      <= {STRB_W{1'b0}};
         pprot_q      <= 3'b000;
         idx_q        <= {IDX_W{1'b0}};
         miss_q       <= 1'b0;
         bvalid_q     <= 1'b0;
         bresp_q      <= 2'b00;
         rvalid_q     <= 1'b0;
         rresp_q      <= 2'b00;
         rdata_q      <= {DATA_W{1'b0}};
      end else begin
         state_q      <= state_d;
         last_write_q <= last_write_d;
         aw_full_q    <= aw_full_d;
         aw_addr_q    <= aw_addr_d;
         aw_prot_q    <= aw_prot_d;
         w_full_q     <= w_full_d;
         w_data_q     <= w_data_d;
         w_strb_q     <= w_strb_d;
         ar_full_q    <= ar_full_d;
         ar_addr_q    <= ar_addr_d;
         ar_prot_q    <= ar_prot_d;
         paddr_q      <= paddr_d;
         psel_q       <= psel_d;
         penable_q    <= penable_d;
         pwrite_q     <= pwrite_d;
         pwdata_q     <= pwdata_d;
         pstrb_q      <= pstrb_d;
         pprot_q      <= pprot_d;
         idx_q        <= idx_d;
         miss_q       <= miss_d;
         bvalid_q     <= bvalid_d;
         bresp_q      <= bresp_d;
         rvalid_q     <= rvalid_d;
         rresp_q      <= rresp_d;
         rdata_q      <= rdata_d;
      end
   end

   assign awready = ~aw_full_q;
   assign wready  = ~w_full_q;
   assign arready = ~ar_full_q;
   assign bvalid  = bvalid_q;
   assign bresp   = bresp_q;
   assign rvalid  = rvalid_q;
   assign rresp   = rresp_q;
   assign rdata   = rdata_q;
   assign paddr   = paddr_q;
   assign psel    = psel_q;
   assign penable = penable_q;
   assign pwrite  = pwrite_q;
   assign pwdata  = pwdata_q;
   assign pstrb   = pstrb_q;
   assign pprot   = pprot_q;

endmodule

// File: tb/tb_axi2apb_bridge_mux.sv
// -----------------------------------------------------------------------------
// tb_axi2apb_bridge_mux
// Directed self-checking bench for axi2apb_bridge_mux (4 completers, 4 KiB
// regions, TIMEOUT_CYCLES = 8). A small completer model answers after
// wait_cfg ACCESS cycles; unselected completers drive noisy pready/pslverr.
// The timeout step is compiled only with AXI2APB_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_axi2apb_bridge_mux;

   localparam int NS = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   awaddr, araddr, wdata;
   logic [2:0]    awprot, arprot;
   logic          awvalid, wvalid, arvalid, bready, rready;
   logic [3:0]    wstrb;
   logic          awready, wready, arready, bvalid, rvalid;
   logic [1:0]    bresp, rresp;
   logic [31:0]   rdata, paddr, pwdata;
   logic [NS-1:0] psel, pready, pslverr;
   logic          penable, pwrite;
   logic [3:0]    pstrb;
   logic [2:0]    pprot;
   logic [NS*32-1:0] prdata;

   int checks   = 0;
   int failures = 0;
   int wait_cfg = 0;
   bit err_cfg  = 1'b0;
   int acc_cnt  = 0;
   int lat;

   // Snapshot of the first cycle psel is seen during a watch window
   logic [NS-1:0] seen_psel, f_psel;
   logic [31:0]   f_paddr, f_pwdata;
   logic [3:0]    f_pstrb;
   logic [2:0]    f_pprot;
   logic          f_pwrite, f_penable, first_done;

   always #5 clk = ~clk;

   axi2apb_bridge_mux #(
      .ADDR_W(32), .DATA_W(32), .NUM_SLAVES(NS), .SLAVE_ADDR_W(12), .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk), .rst(rst),
      .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
      .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   // Completer k returns a distinct word; completer 3 returns 0x1234.
   assign prdata = {32'h0000_1234, 32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000};

   // Count ACCESS wait cycles for the completer model.
   always @(posedge clk) begin
      if (penable && (psel != 4'b0000) && (acc_cnt != wait_cfg)) acc_cnt <= acc_cnt + 1;
      else acc_cnt <= 0;
   end

   // All completers raise pready together; pslverr is inverted on unselected ones.
   always_comb begin
      pready  = (penable && (acc_cnt == wait_cfg)) ? 4'b1111 : 4'b0000;
      pslverr = err_cfg ? psel : ~psel;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Step until bvalid (want_r=0) or rvalid (want_r=1); lat counts edges from T.
   task automatic watch(input bit want_r, output int l);
      bit got;
      got = 1'b0; l = 0; seen_psel = '0; first_done = 1'b0;
      f_psel = '0; f_paddr = '0; f_pwdata = '0; f_pstrb = '0; f_pprot = '0;
      f_pwrite = 1'bx; f_penable = 1'bx;
      for (int i = 1; i <= 60 && !got; i++) begin
         @(posedge clk);
         #1;
         if (psel != 4'b0000) begin
            seen_psel = seen_psel | psel;
            if (!first_done) begin
               first_done = 1'b1;
               f_psel = psel; f_paddr = paddr; f_pwdata = pwdata; f_pstrb = pstrb;
               f_pprot = pprot; f_pwrite = pwrite; f_penable = penable;
            end
         end
         if ((!want_r && bvalid) || (want_r && rvalid)) begin
            got = 1'b1;
            l = i;
         end
      end
      chk(want_r ? "rvalid_arrives" : "bvalid_arrives", got, 1'b1);
   endtask

   initial begin
      rst = 1'b1;
      awaddr = '0; awprot = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wvalid = 1'b0;
      araddr = '0; arprot = '0; arvalid = 1'b0;
      bready = 1'b0; rready = 1'b0;
      step(3);

      // Reset state
      chk("rst_awready", awready, 1'b1);
      chk("rst_wready", wready, 1'b1);
      chk("rst_arready", arready, 1'b1);
      chk("rst_bvalid", bvalid, 1'b0);
      chk("rst_rvalid", rvalid, 1'b0);
      chk("rst_psel", psel, 4'b0000);
      chk("rst_penable", penable, 1'b0);
      chk("rst_pwrite", pwrite, 1'b0);
      chk("rst_paddr", paddr, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      rst = 1'b0;
      step(1);

      // Write 0x1004 to completer 1 with two wait states
      awaddr = 32'h0000_1004; awprot = 3'b001; awvalid = 1'b1;
      wdata = 32'hA5A5_0001; wstrb = 4'hF; wvalid = 1'b1;
      wait_cfg = 2; err_cfg = 1'b0;
      step(1);
      awvalid = 1'b0; wvalid = 1'b0;
      chk("wr_awready_drop", awready, 1'b0);
      chk("wr_wready_drop", wready, 1'b0);
      watch(1'b0, lat);
      chk("wr_latency", lat, 5);
      chk("wr_psel", f_psel, 4'b0010);
      chk("wr_setup_penable", f_penable, 1'b0);
      chk("wr_paddr", f_paddr, 32'h0000_1004);
      chk("wr_pwdata", f_pwdata, 32'hA5A5_0001);
      chk("wr_pstrb", f_pstrb, 4'hF);
      chk("wr_pprot", f_pprot, 3'b001);
      chk("wr_pwrite", f_pwrite, 1'b1);
      chk("wr_bresp", bresp, 2'b00);
      chk("wr_awready_freed", awready, 1'b1);
      bready = 1'b1;
      step(1);
      bready = 1'b0;
      chk("wr_bvalid_clear", bvalid, 1'b0);

      // Read 0x3010 from completer 3 which flags pslverr
      araddr = 32'h0000_3010; arprot = 3'b010; arvalid = 1'b1;
      wait_cfg = 0; err_cfg = 1'b1;
      step(1);
      arvalid = 1'b0;
      chk("rd_arready_drop", arready, 1'b0);
      watch(1'b1, lat);
      chk("rd_latency", lat, 3);
      chk("rd_psel", f_psel, 4'b1000);
      chk("rd_pstrb", f_pstrb, 4'h0);
      chk("rd_pwdata", f_pwdata, 32'h0);
      chk("rd_pwrite", f_pwrite, 1'b0);
      chk("rd_pprot", f_pprot, 3'b010);
      chk("rd_rdata", rdata, 32'h0000_1234);
      chk("rd_rresp", rresp, 2'b10);
      rready = 1'b1;
      step(1);
      rready = 1'b0;
      chk("rd_rvalid_clear", rvalid, 1'b0);

      // Decode misses: write 0x4000, then read 0x8_0000
      err_cfg = 1'b0;
      awaddr = 32'h0000_4000; awvalid = 1'b1;
      wdata = 32'h5555_AAAA; wstrb = 4'h3; wvalid = 1'b1;
      step(1);
      awvalid = 1'b0; wvalid = 1'b0;
      watch(1'b0, lat);
      chk("dec_wr_latency", lat, 2);
      chk("dec_wr_no_psel", seen_psel, 4'b0000);
      chk("dec_wr_bresp", bresp, 2'b11);
      bready = 1'b1;
      step(1);
      bready = 1'b0;
      araddr = 32'h0008_0000; arvalid = 1'b1;
      step(1);
      arvalid = 1'b0;
      watch(1'b1, lat);
      chk("dec_rd_latency", lat, 2);
      chk("dec_rd_no_psel", seen_psel, 4'b0000);
      chk("dec_rd_rresp", rresp, 2'b11);
      chk("dec_rd_rdata", rdata, 32'h0);
      rready = 1'b1;
      step(1);
      rready = 1'b0;

      // W first, then AW and AR on the same edge: write wins, read follows B
      wdata = 32'h0000_00C3; wstrb = 4'h1; wvalid = 1'b1;
      step(1);
      wvalid = 1'b0;
      chk("sim_w_only_wready", wready, 1'b0);
      chk("sim_w_only_awready", awready, 1'b1);
      awaddr = 32'h0000_2008; awvalid = 1'b1;
      araddr = 32'h0000_0020; arvalid = 1'b1;
      step(1);
      awvalid = 1'b0; arvalid = 1'b0;
      chk("sim_arready_drop", arready, 1'b0);
      watch(1'b0, lat);
      chk("sim_wr_latency", lat, 3);
      chk("sim_first_pwrite", f_pwrite, 1'b1);
      chk("sim_wr_psel", f_psel, 4'b0100);
      chk("sim_wr_paddr", f_paddr, 32'h0000_2008);
      chk("sim_wr_pwdata", f_pwdata, 32'h0000_00C3);
      chk("sim_wr_pstrb", f_pstrb, 4'h1);
      chk("sim_wr_bresp", bresp, 2'b00);
      step(2);
      chk("sim_rd_held_psel", psel, 4'b0000);
      chk("sim_bvalid_held", bvalid, 1'b1);
      bready = 1'b1;
      step(1);
      bready = 1'b0;
      watch(1'b1, lat);
      chk("sim_rd_pwrite", f_pwrite, 1'b0);
      chk("sim_rd_psel", f_psel, 4'b0001);
      chk("sim_rd_paddr", f_paddr, 32'h0000_0020);
      chk("sim_rd_rdata", rdata, 32'hDEAD_0000);
      chk("sim_rd_rresp", rresp, 2'b00);
      chk("sim_arready_freed", arready, 1'b1);
      rready = 1'b1;
      step(1);
      rready = 1'b0;

      // Reset pulsed during ACCESS
      awaddr = 32'h0000_1000; awvalid = 1'b1;
      wdata = 32'h1111_2222; wstrb = 4'hF; wvalid = 1'b1;
      wait_cfg = 255;
      step(1);
      awvalid = 1'b0; wvalid = 1'b0;
      step(3);
      chk("mid_pre_penable", penable, 1'b1);
      chk("mid_pre_psel", psel, 4'b0010);
      rst = 1'b1;
      #1;
      chk("mid_async_psel", psel, 4'b0000);
      chk("mid_async_penable", penable, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(2);
      chk("mid_awready", awready, 1'b1);
      chk("mid_wready", wready, 1'b1);
      chk("mid_arready", arready, 1'b1);
      chk("mid_bvalid", bvalid, 1'b0);
      chk("mid_paddr", paddr, 32'h0);

`ifdef AXI2APB_TIMEOUT_EN
      // Completer never answers: ACCESS ends after 8 cycles with SLVERR
      awaddr = 32'h0000_1000; awvalid = 1'b1;
      wdata = 32'h3333_4444; wstrb = 4'hF; wvalid = 1'b1;
      wait_cfg = 255;
      step(1);
      awvalid = 1'b0; wvalid = 1'b0;
      watch(1'b0, lat);
      chk("tmo_latency", lat, 10);
      chk("tmo_bresp", bresp, 2'b10);
      chk("tmo_psel", psel, 4'b0000);
      chk("tmo_penable", penable, 1'b0);
      bready = 1'b1;
      step(1);
      bready = 1'b0;
`endif
      wait_cfg = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
